time_keeper: RTL and testbench
==============================

# time_keeper

Parametrised time-of-day counter for the alarm clock datapath. It keeps hours, minutes and seconds in binary and derives a one-second tick from the system clock through a programmable prescaler. It supports a validated BCD load of hours, minutes and seconds, a run-time 12/24-hour display mode, and single-cycle second-tick and midnight-wrap strobes for the alarm comparator and display blocks. It is the successor to `clock_counter`.

## Interface
- `TICK_DIV`, default 1: clk cycles per second; must be ≥1; 1 = one second per enabled clk.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `en` in 1: count enable; gates the prescaler.
- `LD_time` in 1: level load request; has priority over counting.
- `H_in1` in 2: hour tens digit, BCD, 24-h encoding.
- `H_in0` in 4: hour units digit, BCD.
- `M_in1` in 4: minute tens digit, BCD.
- `M_in0` in 4: minute units digit, BCD.
- `S_in1` in 4: second tens digit, BCD.
- `S_in0` in 4: second units digit, BCD.
- `mode_12h` in 1: 1 selects 12-h presentation on `disp_hour`.
- `tmp_hour` out 6: binary hour 0–23, always 24-h.
- `tmp_minute` out 6: binary minute 0–59.
- `tmp_second` out 6: binary second 0–59.
- `disp_hour` out 5: `tmp_hour` in 24-h mode; 1–12 in 12-h mode.
- `pm` out 1: high when `tmp_hour` ≥ 12, in both modes.
- `sec_tick` out 1: one-cycle strobe per counted second.
- `day_wrap` out 1: one-cycle strobe on 23:59:59 → 00:00:00.
- `load_err` out 1: one-cycle strobe on a rejected load.

## Operation
- Prescaler `pre`, width clog2(TICK_DIV) (min 1). It advances only when `en`=1 and `LD_time`=0, wrapping at TICK_DIV-1. For TICK_DIV=1 every qualifying edge is a second.
- Second step: a qualifying edge with `pre`==TICK_DIV-1 increments seconds. Seconds 59 → 0 with minute carry; minutes 59 → 0 with hour carry; hours 23 → 0.
- Load: on every edge with `LD_time`=1, the inputs are decoded to binary (10·tens + units) and validated: H_in1≤2, H_in0≤9, hour≤23, M_in1≤5, M_in0≤9, S_in1≤5, S_in0≤9.
  - Valid load: writes H/M/S and clears `pre`.
  - Invalid load: leaves H/M/S unchanged, clears `pre`, and pulses `load_err`.
- Holding `LD_time` reloads every cycle; counting resumes on the first edge with `LD_time`=0, starting from `pre`=0.
- `en`=0 freezes `pre` and the time. Loading still works while disabled.
- 12-h mapping (combinational):
  - hour 0 → 12
  - hours 1–12 → unchanged
  - hours 13–23 → hour-12
- `mode_12h` affects only `disp_hour`; it may change at any time without disturbing the count.

## Timing
- Reset (async assert, sync to the next edge after deassert):
  - H/M/S and `pre` = 0.
  - `sec_tick`, `day_wrap`, `load_err` = 0.
  - `disp_hour` = 0 (24-h) or 12 (12-h); `pm` = 0.
- All state is registered. The time registers update on the same edge that consumes the terminal prescaler count.
- `sec_tick` is registered. It is high for exactly the one cycle in which the new second value is visible.
- `day_wrap` is registered and coincident with the `sec_tick` that shows 00:00:00.
- `load_err` is registered. It is high in the cycle after the rejecting edge, and repeats each cycle while an invalid `LD_time` is held.
- A load in the same cycle as a terminal prescaler count: the load wins, and no `sec_tick` or `day_wrap` is produced.
- Latency: with `en` held from `pre`=0, the first `sec_tick` appears TICK_DIV edges later. The subsequent period is TICK_DIV cycles.
- Reset mid-load or mid-count aborts immediately; there is no partial update.

## Test plan
- Reset, then load 01:20:00 for 20 cycles with TICK_DIV=1. Outputs read 01:20:00 throughout the load. After release, seconds read 1, 2, … one per cycle, with `sec_tick` high every cycle.
- TICK_DIV=4: load 23:59:58, release, `en`=1. `sec_tick` fires every 4th cycle; times 23:59:59 then 00:00:00, with `day_wrap` high only in the 00:00:00 tick cycle.
- Invalid loads are each rejected with one `load_err` pulse and the time unchanged:
  - H=2,4 (24:00)
  - M=6,0
  - S_in0=10
- Hour sweep 0, 11, 12, 13, 23 with `mode_12h`=1: `disp_hour`/`pm` = 12/0, 11/0, 12/1, 1/1, 11/1. With `mode_12h`=0, `disp_hour` equals `tmp_hour`.
- `en`=0 for 10 cycles mid-count: time and `pre` hold and there is no `sec_tick`. On re-enable the remaining prescaler count completes before the next tick.
- Assert `reset` asynchronously between edges during counting: all outputs are 0 immediately, and counting restarts from 00:00:00 after release.

Source files
------------

// File: rtl/time_keeper.sv
// Time-of-day counter: binary H/M/S driven by a programmable one-second prescaler,
// with validated BCD load, 12/24-hour presentation and second/midnight strobes.
module time_keeper #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       LD_time,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       mode_12h,
  output logic [5:0] tmp_hour,
  output logic [5:0] tmp_minute,
  output logic [5:0] tmp_second,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
    return ({4'd0, tens} << 3) + ({4'd0, tens} << 1) + {4'd0, units};
  endfunction

  function automatic logic digits_ok(input logic [3:0] tens, input logic [3:0] units,
                                     input logic [3:0] tens_max);
    return (tens <= tens_max) && (units <= 4'd9);
  endfunction

  logic [PRE_W-1:0] pre_r,    pre_nx_s;
  logic [5:0]       hour_r,   hour_nx_s;
  logic [5:0]       minute_r, minute_nx_s;
  logic [5:0]       second_r, second_nx_s;
  logic             tick_r,   tick_nx_s;
  logic             wrap_r,   wrap_nx_s;
  logic             err_r,    err_nx_s;

  logic [7:0] hour_bin_s, minute_bin_s, second_bin_s;
  logic       load_ok_s;

  // Decode and validate the BCD load fields
  always_comb begin
    hour_bin_s   = bcd_to_bin({2'b00, H_in1}, H_in0);
    minute_bin_s = bcd_to_bin(M_in1, M_in0);
    second_bin_s = bcd_to_bin(S_in1, S_in0);
    load_ok_s    = digits_ok({2'b00, H_in1}, H_in0, 4'd2) && (hour_bin_s   <= 8'd23) &&
                   digits_ok(M_in1, M_in0, 4'd5)          && (minute_bin_s <= 8'd59) &&
                   digits_ok(S_in1, S_in0, 4'd5)          && (second_bin_s <= 8'd59);
  end

  // Next-state: load has priority, then prescaled counting, else hold
  always_comb begin
    pre_nx_s    = pre_r;
    hour_nx_s   = hour_r;
    minute_nx_s = minute_r;
    second_nx_s = second_r;
    tick_nx_s   = 1'b0;
    wrap_nx_s   = 1'b0;
    err_nx_s    = 1'b0;
    if (LD_time) begin
      pre_nx_s = '0;
      if (load_ok_s) begin
        hour_nx_s   = hour_bin_s[5:0];
        minute_nx_s = minute_bin_s[5:0];
        second_nx_s = second_bin_s[5:0];
      end else begin
        err_nx_s = 1'b1;
      end
    end else if (en) begin
      if (pre_r == PRE_LAST) begin
        pre_nx_s  = '0;
        tick_nx_s = 1'b1;
        if (second_r == 6'd59) begin
          second_nx_s = 6'd0;
          if (minute_r == 6'd59) begin
            minute_nx_s = 6'd0;
            if (hour_r == 6'd23) begin
              hour_nx_s = 6'd0;
              wrap_nx_s = 1'b1;
            end else begin
              hour_nx_s = hour_r + 6'd1;
            end
          end else begin
            minute_nx_s = minute_r + 6'd1;
          end
        end else begin
          second_nx_s = second_r + 6'd1;
        end
      end else begin
        pre_nx_s = pre_r + PRE_W'(1);
      end
    end else begin
      pre_nx_s = pre_r;
    end
  end

  // State and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r    <= '0;
      hour_r   <= 6'd0;
      minute_r <= 6'd0;
      second_r <= 6'd0;
      tick_r   <= 1'b0;
      wrap_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      pre_r    <= pre_nx_s;
      hour_r   <= hour_nx_s;
      minute_r <= minute_nx_s;
      second_r <= second_nx_s;
      tick_r   <= tick_nx_s;
      wrap_r   <= wrap_nx_s;
      err_r    <= err_nx_s;
    end
  end

  // 12-hour presentation: 0 shows as 12, afternoon hours fold down by 12
  always_comb begin
    if (!mode_12h) begin
      disp_hour = hour_r[4:0];
    end else if (hour_r == 6'd0) begin
      disp_hour = 5'd12;
    end else if (hour_r > 6'd12) begin
      disp_hour = hour_r[4:0] - 5'd12;
    end else begin
      disp_hour = hour_r[4:0];
    end
    pm = (hour_r >= 6'd12);
  end

  assign tmp_hour   = hour_r;
  assign tmp_minute = minute_r;
  assign tmp_second = second_r;
  assign sec_tick   = tick_r;
  assign day_wrap   = wrap_r;
  assign load_err   = err_r;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: one instance with TICK_DIV=1, one with TICK_DIV=4,
// sharing stimulus; each test checks whichever instance it targets.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset, en, LD_time, mode_12h;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;

  logic [5:0] a_hour, a_min, a_sec, b_hour, b_min, b_sec;
  logic [4:0] a_disp, b_disp;
  logic       a_pm, a_tick, a_wrap, a_err, b_pm, b_tick, b_wrap, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  time_keeper #(.TICK_DIV(1)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .LD_time(LD_time),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0), .S_in1(S_in1), .S_in0(S_in0),
    .mode_12h(mode_12h), .tmp_hour(a_hour), .tmp_minute(a_min), .tmp_second(a_sec),
    .disp_hour(a_disp), .pm(a_pm), .sec_tick(a_tick), .day_wrap(a_wrap), .load_err(a_err)
  );

  time_keeper #(.TICK_DIV(4)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .LD_time(LD_time),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0), .S_in1(S_in1), .S_in0(S_in0),
    .mode_12h(mode_12h), .tmp_hour(b_hour), .tmp_minute(b_min), .tmp_second(b_sec),
    .disp_hour(b_disp), .pm(b_pm), .sec_tick(b_tick), .day_wrap(b_wrap), .load_err(b_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hms(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    return int'(h) * 10000 + int'(m) * 100 + int'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    H_in1 = 2'(h1); H_in0 = 4'(h0);
    M_in1 = 4'(m1); M_in0 = 4'(m0);
    S_in1 = 4'(s1); S_in0 = 4'(s0);
  endtask

  int hours   [5] = '{0, 11, 12, 13, 23};
  int disp12  [5] = '{12, 11, 12, 1, 11};
  int pm_exp  [5] = '{0, 0, 1, 1, 1};

  initial begin
    reset = 1'b1; en = 1'b0; LD_time = 1'b0; mode_12h = 1'b0;
    set_load(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // reset state
    check_val("rst_a_time", hms(a_hour, a_min, a_sec), 0);
    check_val("rst_a_disp", a_disp, 0);
    check_val("rst_a_pm", a_pm, 0);
    check_val("rst_a_strobes", {a_tick, a_wrap, a_err}, 0);
    check_val("rst_b_time", hms(b_hour, b_min, b_sec), 0);
    check_val("rst_b_outs", {b_disp, b_pm, b_tick, b_wrap, b_err}, 0);
    mode_12h = 1'b1;
    #1;
    check_val("rst_a_disp12", a_disp, 12);
    check_val("rst_a_pm12", a_pm, 0);
    mode_12h = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // held load of 01:20:00, then one second per cycle on TICK_DIV=1
    set_load(0, 1, 2, 0, 0, 0);
    LD_time = 1'b1; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("hold_a_time", hms(a_hour, a_min, a_sec), 12000);
      check_val("hold_a_tick", a_tick, 0);
    end
    LD_time = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_val("run_a_time", hms(a_hour, a_min, a_sec), 12000 + k);
      check_val("run_a_tick", a_tick, 1);
    end

    // TICK_DIV=4 midnight rollover from 23:59:58
    set_load(2, 3, 5, 9, 5, 8);
    LD_time = 1'b1;
    step();
    check_val("wrap_b_load", hms(b_hour, b_min, b_sec), 235958);
    LD_time = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check_val("wrap_b_time", hms(b_hour, b_min, b_sec),
                (c < 4) ? 235958 : ((c < 8) ? 235959 : 0));
      check_val("wrap_b_tick", b_tick, (c == 4 || c == 8) ? 1 : 0);
      check_val("wrap_b_day", b_wrap, (c == 8) ? 1 : 0);
    end

    // pause with pre=1: hold, then three more edges finish the second
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("pause_b_time", hms(b_hour, b_min, b_sec), 0);
      check_val("pause_b_tick", b_tick, 0);
    end
    en = 1'b1;
    step();
    check_val("resume_b_tick1", b_tick, 0);
    step();
    check_val("resume_b_tick2", b_tick, 0);
    step();
    check_val("resume_b_tick3", b_tick, 1);
    check_val("resume_b_time", hms(b_hour, b_min, b_sec), 1);

    // rejected loads
    en = 1'b0;
    set_load(1, 0, 3, 0, 1, 5);
    LD_time = 1'b1;
    step();
    check_val("ld_ok_time", hms(a_hour, a_min, a_sec), 103015);
    check_val("ld_ok_err", a_err, 0);
    set_load(2, 4, 0, 0, 0, 0);
    step();
    check_val("bad_h_err", a_err, 1);
    check_val("bad_h_time", hms(a_hour, a_min, a_sec), 103015);
    step();
    check_val("bad_h_err_held", a_err, 1);
    check_val("bad_h_b_err", b_err, 1);
    LD_time = 1'b0;
    step();
    check_val("bad_h_err_clr", a_err, 0);
    check_val("bad_h_time2", hms(a_hour, a_min, a_sec), 103015);

    set_load(1, 0, 6, 0, 1, 5);
    LD_time = 1'b1;
    step();
    check_val("bad_m_err", a_err, 1);
    check_val("bad_m_time", hms(a_hour, a_min, a_sec), 103015);
    LD_time = 1'b0;
    step();
    check_val("bad_m_err_clr", a_err, 0);

    set_load(1, 0, 3, 0, 1, 10);
    LD_time = 1'b1;
    step();
    check_val("bad_s_err", a_err, 1);
    check_val("bad_s_time", hms(a_hour, a_min, a_sec), 103015);
    LD_time = 1'b0;
    step();
    check_val("bad_s_err_clr", a_err, 0);

    // 12/24-hour presentation sweep
    for (int i = 0; i < 5; i++) begin
      set_load(hours[i] / 10, hours[i] % 10, 0, 0, 0, 0);
      LD_time = 1'b1;
      step();
      LD_time = 1'b0;
      check_val("sweep_hour", a_hour, hours[i]);
      mode_12h = 1'b1;
      #1;
      check_val("sweep_disp12", a_disp, disp12[i]);
      check_val("sweep_pm12", a_pm, pm_exp[i]);
      mode_12h = 1'b0;
      #1;
      check_val("sweep_disp24", a_disp, hours[i]);
      check_val("sweep_pm24", a_pm, pm_exp[i]);
    end

    // asynchronous reset between edges while counting from 23:00:00
    en = 1'b1;
    step();
    step();
    check_val("pre_rst_a_time", hms(a_hour, a_min, a_sec), 230002);
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_a_time", hms(a_hour, a_min, a_sec), 0);
    check_val("arst_a_outs", {a_disp, a_pm, a_tick, a_wrap, a_err}, 0);
    check_val("arst_b_time", hms(b_hour, b_min, b_sec), 0);
    step();
    check_val("arst_a_held", hms(a_hour, a_min, a_sec), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_val("restart_a_time", hms(a_hour, a_min, a_sec), 1);
    check_val("restart_a_tick", a_tick, 1);
    check_val("restart_b_tick1", b_tick, 0);
    repeat (3) step();
    check_val("restart_b_time", hms(b_hour, b_min, b_sec), 1);
    check_val("restart_b_tick4", b_tick, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
